// File: rtl/glitch_pulse_scheduler.sv
// Clock-glitch sequencer: waits for a synchronised trigger rise, counts a delay, then emits
// REPEAT glitch pulses of WIDTH cycles separated by GAP cycles on a registered glitch_out.
module glitch_pulse_scheduler #(
  parameter int CNT_W       = 32,
  parameter int REP_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  output logic [CNT_W-1:0] cfg_rdata,
  input  logic             arm,
  input  logic             abort,
  input  logic             trigger,
  output logic             glitch_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [REP_W-1:0] pulse_cnt,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_DELAY = 3'd2,
    S_PULSE = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       delay_r, width_r, gap_r;
  logic [REP_W-1:0]       repeat_r;
  logic [REP_W-1:0]       pcnt_d;
  logic [1:0]             status_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   trig_q;
  logic                   trig_rise, trig_low, active, cfg_ok;
  logic [CNT_W-1:0]       width_m1, gap_m1;
  logic [REP_W-1:0]       rep_eff;

  // Edge detector works purely on flopped values, so the decision costs no extra cycle.
  assign trig_rise = sync_q[SYNC_STAGES-1] & ~trig_q;
  assign trig_low  = ~sync_q[SYNC_STAGES-1];

  assign busy      = (state_q == S_ARMED) || (state_q == S_DELAY) ||
                     (state_q == S_PULSE) || (state_q == S_GAP);
  assign done      = (state_q == S_DONE);
  assign active    = (state_q == S_DELAY) || (state_q == S_PULSE) || (state_q == S_GAP);
  assign cfg_ok    = cfg_we && !busy;
  assign dbg_state = state_q;

  // Zero-valued WIDTH/GAP/REPEAT are treated as one.
  assign width_m1 = (width_r == '0) ? '0 : width_r - CNT_W'(1);
  assign gap_m1   = (gap_r == '0) ? '0 : gap_r - CNT_W'(1);
  assign rep_eff  = (repeat_r == '0) ? REP_W'(1) : repeat_r;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
      trig_q <= 1'b0;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(trigger);
      trig_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      delay_r  <= '0;
      width_r  <= CNT_W'(1);
      gap_r    <= CNT_W'(1);
      repeat_r <= REP_W'(1);
    end else if (cfg_ok) begin
      case (cfg_addr)
        3'd0:    delay_r  <= cfg_wdata;
        3'd1:    width_r  <= cfg_wdata;
        3'd2:    gap_r    <= cfg_wdata;
        3'd3:    repeat_r <= cfg_wdata[REP_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pulse_cnt  <= '0;
      status     <= 2'd0;
      glitch_out <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pulse_cnt  <= pcnt_d;
      status     <= status_d;
      glitch_out <= (state_d == S_PULSE);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pcnt_d   = pulse_cnt;
    status_d = status;
    // Abort outranks trigger loss; both outrank normal sequencing.
    if (busy && abort) begin
      state_d  = S_DONE;
      status_d = 2'd2;
    end else if (active && trig_low) begin
      state_d  = S_DONE;
      status_d = 2'd3;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm && !abort) begin
            state_d  = S_ARMED;
            pcnt_d   = '0;
            status_d = 2'd0;
          end
        end
        S_ARMED: begin
          if (trig_rise) begin
            state_d = S_DELAY;
            cnt_d   = delay_r;
          end
        end
        S_DELAY, S_GAP: begin
          if (cnt_q == '0) begin
            state_d = S_PULSE;
            cnt_d   = width_m1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_PULSE: begin
          if (cnt_q == '0) begin
            pcnt_d = (pulse_cnt == '1) ? pulse_cnt : pulse_cnt + REP_W'(1);
            if (({1'b0, pulse_cnt} + (REP_W+1)'(1)) == {1'b0, rep_eff}) begin
              state_d  = S_DONE;
              status_d = 2'd1;
            end else begin
              state_d = S_GAP;
              cnt_d   = gap_m1;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_DONE: begin
          if (abort) begin
            state_d = S_DONE;
          end else if (arm) begin
            state_d  = S_ARMED;
            pcnt_d   = '0;
            status_d = 2'd0;
          end else if (cfg_we && cfg_addr == 3'd4) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      3'd0:    cfg_rdata = delay_r;
      3'd1:    cfg_rdata = width_r;
      3'd2:    cfg_rdata = gap_r;
      3'd3:    cfg_rdata = CNT_W'(repeat_r);
      3'd4:    cfg_rdata = CNT_W'({pulse_cnt, status, done, busy});
      default: cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_glitch_pulse_scheduler.sv
// Bench for glitch_pulse_scheduler: per-sequence waveform predicted from pulse-train arithmetic,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_glitch_pulse_scheduler;
  localparam int CNT_W = 32;
  localparam int REP_W = 8;
  localparam int S     = 2;
  localparam int INF   = 1 << 30;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             cfg_we = 1'b0;
  logic [2:0]       cfg_addr = 3'd0;
  logic [CNT_W-1:0] cfg_wdata = '0;
  logic [CNT_W-1:0] cfg_rdata;
  logic             arm = 1'b0;
  logic             abort = 1'b0;
  logic             trigger = 1'b0;
  logic             glitch_out, busy, done;
  logic [1:0]       status;
  logic [REP_W-1:0] pulse_cnt;
  logic [2:0]       dbg_state;

  int       cyc = 0;
  int       n_vec = 0;
  int       n_err = 0;
  logic     glog [0:8191];
  bit       chk_en = 1'b0;
  logic [2:0] exp_q[$];
  logic [2:0] ex_v;
  int       m_a, m_k;

  glitch_pulse_scheduler #(.CNT_W(CNT_W), .REP_W(REP_W), .SYNC_STAGES(S)) dut (
    .clk(clk), .resetn(resetn), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .arm(arm), .abort(abort), .trigger(trigger),
    .glitch_out(glitch_out), .busy(busy), .done(done), .status(status),
    .pulse_cnt(pulse_cnt), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // per-cycle scoreboard: {glitch_out, busy, done}
  always @(negedge clk) begin
    glog[cyc % 8192] = glitch_out;
    if (chk_en && exp_q.size() > 0) begin
      ex_v = exp_q.pop_front();
      check("glitch_out", glitch_out, ex_v[2]);
      check("busy", busy, ex_v[1]);
      check("done", done, ex_v[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [CNT_W-1:0] v);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = v;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input string name, input logic [2:0] a, input logic [63:0] exp);
    cfg_addr = a;
    #1;
    check(name, cfg_rdata, exp);
  endtask

  // One full sequence. Offsets are in clock edges: rise_off after the ARMED edge the trigger
  // is first sampled high; lost_off after that it is first sampled low; ab_off after the ARMED
  // edge abort is sampled. 0 disables lost/abort.
  task automatic run_seq(input int d, input int w, input int g, input int r, input int rise_off,
                         input int lost_off, input int ab_off, input bit pre_high);
    int k, f, tab, tn, tl, t, st, pc, we, ge, re, s0, e, si;
    logic gv;
    cfg_write(3'd0, d); cfg_write(3'd1, w); cfg_write(3'd2, g); cfg_write(3'd3, r);
    if (pre_high) begin
      trigger = 1'b1;
      repeat (S + 3) step();
    end
    arm = 1'b1;
    step();
    arm = 1'b0;
    m_a = cyc;
    k   = m_a + rise_off;
    m_k = k;
    we  = (w == 0) ? 1 : w;
    ge  = (g == 0) ? 1 : g;
    re  = (r == 0) ? 1 : r;
    s0  = k + S + d + 1;
    tn  = s0 + (re - 1) * (we + ge) + we;
    f   = (lost_off > 0) ? k + lost_off : INF;
    tl  = (lost_off > 0) ? f + S : INF;
    tab = (ab_off > 0) ? m_a + ab_off : INF;
    t = tn;
    if (tl < t) t = tl;
    if (tab < t) t = tab;
    if (tab <= tn && tab <= tl) st = 2;
    else if (tl <= tn) st = 3;
    else st = 1;
    pc = 0;
    for (int i = 0; i < re; i++) begin
      si = s0 + i * (we + ge);
      if (st == 1 || si + we < t) pc++;
    end
    for (int ee = m_a; ee <= t + 3; ee++) begin
      gv = 1'b0;
      for (int i = 0; i < re; i++) begin
        si = s0 + i * (we + ge);
        if (ee >= si && ee < si + we && ee < t) gv = 1'b1;
      end
      exp_q.push_back({gv, logic'(ee < t), logic'(ee >= t)});
    end
    chk_en = 1'b1;
    while (cyc < t + 3) begin
      e = cyc + 1;
      trigger = (pre_high && e < m_a + 2) || (e >= k && e < f);
      abort = (e == tab);
      step();
    end
    abort = 1'b0;
    trigger = 1'b0;
    check("status_end", status, st);
    check("pulse_cnt_end", pulse_cnt, pc);
    cfg_read("status_reg", 3'd4, (64'(pc) << 4) | (64'(st) << 2) | 64'd2);
    cfg_write(3'd4, '0);
    check("done_after_clear", done, 1'b0);
    check("status_kept", status, st);
    check("scoreboard_drained", exp_q.size(), 0);
    chk_en = 1'b0;
    exp_q.delete();
    repeat (S + 3) step();
  endtask

  initial begin
    int k, a;
    logic [12:0] pat;
    // reset
    repeat (3) step();
    check("rst_glitch", glitch_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_status", status, 2'd0);
    check("rst_pulse_cnt", pulse_cnt, 0);
    cfg_read("rst_delay", 3'd0, 0);
    cfg_read("rst_width", 3'd1, 1);
    cfg_read("rst_gap", 3'd2, 1);
    cfg_read("rst_repeat", 3'd3, 1);
    resetn = 1'b1;
    repeat (4) step();

    // arm together with abort in IDLE stays idle
    arm = 1'b1; abort = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0;
    check("idle_abort_arm_busy", busy, 1'b0);
    check("idle_abort_arm_done", done, 1'b0);

    // T1: single one-cycle pulse, 8 edges after the trigger edge
    run_seq(5, 1, 1, 1, 2, 0, 0, 1'b0);
    check("t1_before", glog[(m_k + 7) % 8192], 1'b0);
    check("t1_pulse", glog[(m_k + 8) % 8192], 1'b1);
    check("t1_after", glog[(m_k + 9) % 8192], 1'b0);
    check("t1_status", status, 2'd1);
    check("t1_pcnt", pulse_cnt, 1);

    // T2: 111 00 111 00 111
    run_seq(0, 3, 2, 3, 1, 0, 0, 1'b0);
    for (int i = 0; i < 13; i++) pat[12 - i] = glog[(m_k + 3 + i) % 8192];
    check("t2_pattern", pat, 13'b1110011100111);
    check("t2_pcnt", pulse_cnt, 3);

    // T3: trigger high at arm, then low, then second rise
    run_seq(2, 2, 1, 2, 5, 0, 0, 1'b1);
    check("t3_first_pulse", glog[(m_k + 5) % 8192], 1'b1);
    check("t3_pre", glog[(m_k + 4) % 8192], 1'b0);
    check("t3_pcnt", pulse_cnt, 2);

    // T4: trigger lost during second of three pulses
    run_seq(0, 2, 2, 3, 2, 6, 0, 1'b0);
    check("t4_high", glog[(m_k + 7) % 8192], 1'b1);
    check("t4_dropped", glog[(m_k + 8) % 8192], 1'b0);
    check("t4_status", status, 2'd3);
    check("t4_pcnt", pulse_cnt, 1);

    // T5: abort+arm during GAP, with a DELAY write that must be ignored
    cfg_write(3'd0, 0); cfg_write(3'd1, 2); cfg_write(3'd2, 6); cfg_write(3'd3, 3);
    arm = 1'b1; step(); arm = 1'b0;
    a = cyc; k = a + 2;
    while (cyc < k + 7) begin
      trigger = (cyc + 1 >= k);
      step();
    end
    check("t5_in_gap", glitch_out, 1'b0);
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 9; abort = 1'b1; arm = 1'b1;
    step();
    cfg_we = 1'b0; abort = 1'b0; arm = 1'b0;
    check("t5_done", done, 1'b1);
    check("t5_status", status, 2'd2);
    check("t5_pcnt", pulse_cnt, 1);
    step();
    check("t5_stays_done", done, 1'b1);
    cfg_read("t5_delay_unchanged", 3'd0, 0);
    trigger = 1'b0;
    cfg_write(3'd4, '0);
    repeat (S + 3) step();

    // T6: reset during PULSE
    cfg_write(3'd0, 0); cfg_write(3'd1, 4); cfg_write(3'd3, 1);
    arm = 1'b1; step(); arm = 1'b0;
    k = cyc + 1;
    while (cyc < k + 4) begin
      trigger = (cyc + 1 >= k);
      step();
    end
    check("t6_in_pulse", glitch_out, 1'b1);
    #1 resetn = 1'b0;
    #1;
    check("t6_async_glitch", glitch_out, 1'b0);
    check("t6_busy", busy, 1'b0);
    cfg_read("t6_width", 3'd1, 1);
    step();
    cfg_read("t6_delay", 3'd0, 0);
    cfg_read("t6_repeat", 3'd3, 1);
    check("t6_status", status, 2'd0);
    trigger = 1'b0;
    resetn = 1'b1;
    repeat (S + 3) step();

    // randomized sequences
    for (int n = 0; n < 30; n++) begin
      int d, w, g, r, ro, lo, ab;
      bit pre;
      d   = $urandom_range(0, 6);
      w   = $urandom_range(0, 4);
      g   = $urandom_range(0, 3);
      r   = $urandom_range(0, 4);
      pre = ($urandom_range(0, 3) == 0);
      ro  = pre ? $urandom_range(4, 8) : $urandom_range(1, 5);
      lo  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : 0;
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0;
      run_seq(d, w, g, r, ro, lo, ab, pre);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
